// File: rtl/rom_port_arbiter.sv
// Shares one asynchronous instruction ROM between the fetch (IF) and load (LD) ports.
// LD has fixed priority, and a starvation guard forces an IF win after STARVE_MAX denials.
module rom_port_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        NORMAL   = 1'b0,
        IF_BOOST = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
    logic             if_bad_c, ld_bad_c;

    // An address is bad if it is not word aligned or lies beyond the ROM.
    assign if_bad_c = (if_addr[1:0] != 2'b00) || (if_addr[31:ADDR_W+2] != '0);
    assign ld_bad_c = (ld_addr[1:0] != 2'b00) || (ld_addr[31:ADDR_W+2] != '0);

    // Arbitration, ROM address select and starvation tracking.
    always_comb begin
        if_gnt         = 1'b0;
        ld_gnt         = 1'b0;
        rom_addr       = '0;
        starve_cnt_nxt = '0;
        state_nxt      = NORMAL;

        if (!rst) begin
            if (state == IF_BOOST && if_req) begin
                if_gnt = 1'b1;
            end else if (ld_req) begin
                ld_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end

        if (if_gnt) begin
            rom_addr = if_addr[ADDR_W+1:2];
        end else if (ld_gnt) begin
            rom_addr = ld_addr[ADDR_W+1:2];
        end

        if (if_req && !if_gnt) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
            if (starve_cnt_nxt == CNT_W'(STARVE_MAX)) begin
                state_nxt = IF_BOOST;
            end
        end
    end

    // State register and registered 1-cycle response path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            if_rvalid  <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= '0;
            ld_rvalid  <= 1'b0;
            ld_err     <= 1'b0;
            ld_rdata   <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;

            // A flushed fetch still consumed the slot but produces no response.
            if_rvalid  <= if_gnt && !if_flush;
            if_err     <= if_gnt && !if_flush && if_bad_c;
            if (if_gnt && !if_flush) begin
                if_rdata <= if_bad_c ? '0 : rom_data;
            end

            ld_rvalid  <= ld_gnt;
            ld_err     <= ld_gnt && ld_bad_c;
            if (ld_gnt) begin
                ld_rdata <= ld_bad_c ? '0 : rom_data;
            end
        end
    end

endmodule
